axil_ctrl_arbiter: RTL

AXIL_CTRL_ARBITER -- requirements
Module: axil_ctrl_arbiter

---
 rtl/axil_arb_pkg.sv | 17 +
 rtl/axil_arb_rr.sv | 32 +++
 rtl/axil_ctrl_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite control arbiter.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RESP    = 3'd5
  } arb_state_e;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/axil_arb_rr.sv
// Two-way round-robin selector; the pointer names the port favoured on a tie.
module axil_arb_rr (
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       served_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic prio_q;

  always_comb begin
    gnt_valid_o = |req_i;
    if (req_i == 2'b11) begin
      gnt_id_o = prio_q;
    end else begin
      gnt_id_o = req_i[1];
    end
  end

  // After a completed transaction the other port gets the tie-break.
  always_ff @(posedge clk) begin
    if (srst) begin
      prio_q <= 1'b0;
    end else if (done_i) begin
      prio_q <= ~served_i;
    end
  end

endmodule

// File: rtl/axil_ctrl_arbiter.sv
// Funnels two AXI4-Lite requesters onto one control master, one transaction at a time,
// with a per-transaction watchdog that answers SLVERR if the downstream slave stalls.
module axil_ctrl_arbiter
  import axil_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              shell_axi_clk,
  input  logic              shell_rst,
  input  logic [ADDR_W-1:0] s0_axil_awaddr,
  input  logic [2:0]        s0_axil_awprot,
  input  logic              s0_axil_awvalid,
  output logic              s0_axil_awready,
  input  logic [31:0]       s0_axil_wdata,
  input  logic [3:0]        s0_axil_wstrb,
  input  logic              s0_axil_wvalid,
  output logic              s0_axil_wready,
  output logic [1:0]        s0_axil_bresp,
  output logic              s0_axil_bvalid,
  input  logic              s0_axil_bready,
  input  logic [ADDR_W-1:0] s0_axil_araddr,
  input  logic [2:0]        s0_axil_arprot,
  input  logic              s0_axil_arvalid,
  output logic              s0_axil_arready,
  output logic [31:0]       s0_axil_rdata,
  output logic [1:0]        s0_axil_rresp,
  output logic              s0_axil_rvalid,
  input  logic              s0_axil_rready,
  input  logic [ADDR_W-1:0] s1_axil_awaddr,
  input  logic [2:0]        s1_axil_awprot,
  input  logic              s1_axil_awvalid,
  output logic              s1_axil_awready,
  input  logic [31:0]       s1_axil_wdata,
  input  logic [3:0]        s1_axil_wstrb,
  input  logic              s1_axil_wvalid,
  output logic              s1_axil_wready,
  output logic [1:0]        s1_axil_bresp,
  output logic              s1_axil_bvalid,
  input  logic              s1_axil_bready,
  input  logic [ADDR_W-1:0] s1_axil_araddr,
  input  logic [2:0]        s1_axil_arprot,
  input  logic              s1_axil_arvalid,
  output logic              s1_axil_arready,
  output logic [31:0]       s1_axil_rdata,
  output logic [1:0]        s1_axil_rresp,
  output logic              s1_axil_rvalid,
  input  logic              s1_axil_rready,
  output logic [ADDR_W-1:0] m_axil_awaddr,
  output logic [2:0]        m_axil_awprot,
  output logic              m_axil_awvalid,
  input  logic              m_axil_awready,
  output logic [31:0]       m_axil_wdata,
  output logic [3:0]        m_axil_wstrb,
  output logic              m_axil_wvalid,
  input  logic              m_axil_wready,
  input  logic [1:0]        m_axil_bresp,
  input  logic              m_axil_bvalid,
  output logic              m_axil_bready,
  output logic [ADDR_W-1:0] m_axil_araddr,
  output logic [2:0]        m_axil_arprot,
  output logic              m_axil_arvalid,
  input  logic              m_axil_arready,
  input  logic [31:0]       m_axil_rdata,
  input  logic [1:0]        m_axil_rresp,
  input  logic              m_axil_rvalid,
  output logic              m_axil_rready,
  output logic              busy,
  output logic              grant_id,
  output logic [15:0]       timeout_count
);

  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        prot_q, prot_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        strb_q, strb_d;
  logic [1:0]        resp_q, resp_d;
  logic              awv_q, awv_d;
  logic              wv_q, wv_d;
  logic              arv_q, arv_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [15:0]       tcnt_q, tcnt_d;
  logic              tmo_fire;

  logic [1:0]        req_wr;
  logic [1:0]        req_rd;
  logic              win_valid;
  logic              win_id;
  logic              wr_sel;
  logic              accept;
  logic              accept_wr;
  logic              accept_rd;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_prot;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_wstrb;
  logic              s_ready_sel;
  logic              rr_done;
  logic              tmo_last;

  assign req_wr = {s1_axil_awvalid & s1_axil_wvalid, s0_axil_awvalid & s0_axil_wvalid};
  assign req_rd = {s1_axil_arvalid, s0_axil_arvalid};

  axil_arb_rr u_rr (
    .clk         (shell_axi_clk),
    .srst        (shell_rst),
    .req_i       (req_wr | req_rd),
    .done_i      (rr_done),
    .served_i    (grant_q),
    .gnt_valid_o (win_valid),
    .gnt_id_o    (win_id)
  );

  // Readies are gated by reset so no handshake can complete while the core is held.
  assign wr_sel    = req_wr[win_id];
  assign accept    = (state_q == IDLE) && win_valid && !shell_rst;
  assign accept_wr = accept && wr_sel;
  assign accept_rd = accept && !wr_sel;

  assign s0_axil_awready = accept_wr && !win_id;
  assign s0_axil_wready  = accept_wr && !win_id;
  assign s0_axil_arready = accept_rd && !win_id;
  assign s1_axil_awready = accept_wr && win_id;
  assign s1_axil_wready  = accept_wr && win_id;
  assign s1_axil_arready = accept_rd && win_id;

  assign sel_addr  = win_id ? (wr_sel ? s1_axil_awaddr : s1_axil_araddr)
                            : (wr_sel ? s0_axil_awaddr : s0_axil_araddr);
  assign sel_prot  = win_id ? (wr_sel ? s1_axil_awprot : s1_axil_arprot)
                            : (wr_sel ? s0_axil_awprot : s0_axil_arprot);
  assign sel_wdata = win_id ? s1_axil_wdata : s0_axil_wdata;
  assign sel_wstrb = win_id ? s1_axil_wstrb : s0_axil_wstrb;

  assign s_ready_sel = grant_q ? (is_wr_q ? s1_axil_bready : s1_axil_rready)
                               : (is_wr_q ? s0_axil_bready : s0_axil_rready);
  assign rr_done  = (state_q == RESP) && s_ready_sel;
  assign tmo_last = (tmo_q == 16'd1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    prot_d   = prot_q;
    data_d   = data_q;
    strb_d   = strb_q;
    resp_d   = resp_q;
    awv_d    = awv_q;
    wv_d     = wv_q;
    arv_d    = arv_q;
    tmo_d    = tmo_q;
    tcnt_d   = tcnt_q;
    tmo_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          grant_d = win_id;
          is_wr_d = wr_sel;
          addr_d  = sel_addr;
          prot_d  = sel_prot;
          resp_d  = RESP_OKAY;
          tmo_d   = TMO_LOAD;
          if (wr_sel) begin
            data_d  = sel_wdata;
            strb_d  = sel_wstrb;
            awv_d   = 1'b1;
            wv_d    = 1'b1;
            state_d = WR_REQ;
          end else begin
            arv_d   = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        tmo_d = tmo_q - 16'd1;
        if (m_axil_awready) awv_d = 1'b0;
        if (m_axil_wready)  wv_d  = 1'b0;
        if ((!awv_q || m_axil_awready) && (!wv_q || m_axil_wready)) begin
          state_d = WR_RESP;
        end else if (tmo_last) begin
          tmo_fire = 1'b1;
        end
      end
      WR_RESP: begin
        tmo_d = tmo_q - 16'd1;
        if (m_axil_bvalid) begin
          resp_d  = m_axil_bresp;
          state_d = RESP;
        end else if (tmo_last) begin
          tmo_fire = 1'b1;
        end
      end
      RD_REQ: begin
        tmo_d = tmo_q - 16'd1;
        if (m_axil_arready) begin
          arv_d   = 1'b0;
          state_d = RD_RESP;
        end else if (tmo_last) begin
          tmo_fire = 1'b1;
        end
      end
      RD_RESP: begin
        tmo_d = tmo_q - 16'd1;
        if (m_axil_rvalid) begin
          data_d  = m_axil_rdata;
          resp_d  = m_axil_rresp;
          state_d = RESP;
        end else if (tmo_last) begin
          tmo_fire = 1'b1;
        end
      end
      RESP: begin
        if (s_ready_sel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A late downstream response after this is swallowed by the IDLE readies.
    if (tmo_fire) begin
      awv_d   = 1'b0;
      wv_d    = 1'b0;
      arv_d   = 1'b0;
      resp_d  = RESP_SLVERR;
      if (!is_wr_q) data_d = TIMEOUT_RDATA;
      if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
      state_d = RESP;
    end
  end

  always_ff @(posedge shell_axi_clk) begin
    if (shell_rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      prot_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      resp_q  <= RESP_OKAY;
      awv_q   <= 1'b0;
      wv_q    <= 1'b0;
      arv_q   <= 1'b0;
      tmo_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      prot_q  <= prot_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      resp_q  <= resp_d;
      awv_q   <= awv_d;
      wv_q    <= wv_d;
      arv_q   <= arv_d;
      tmo_q   <= tmo_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = prot_q;
  assign m_axil_awvalid = awv_q;
  assign m_axil_wdata   = data_q;
  assign m_axil_wstrb   = strb_q;
  assign m_axil_wvalid  = wv_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = prot_q;
  assign m_axil_arvalid = arv_q;
  assign m_axil_bready  = (state_q == IDLE) || (state_q == WR_RESP);
  assign m_axil_rready  = (state_q == IDLE) || (state_q == RD_RESP);

  assign s0_axil_bvalid = (state_q == RESP) && is_wr_q && !grant_q;
  assign s0_axil_rvalid = (state_q == RESP) && !is_wr_q && !grant_q;
  assign s1_axil_bvalid = (state_q == RESP) && is_wr_q && grant_q;
  assign s1_axil_rvalid = (state_q == RESP) && !is_wr_q && grant_q;
  assign s0_axil_bresp  = resp_q;
  assign s0_axil_rresp  = resp_q;
  assign s0_axil_rdata  = data_q;
  assign s1_axil_bresp  = resp_q;
  assign s1_axil_rresp  = resp_q;
  assign s1_axil_rdata  = data_q;

  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_q;
  assign timeout_count = tcnt_q;

endmodule
